// File: rtl/mnist_layer_sched.sv
// Per-image scheduler for the three-layer MNIST datapath: issues one start per
// neuron to each layer controller in order, tracks images and guards each start with a watchdog.
module mnist_layer_sched #(
  parameter int unsigned L1_N    = 64,
  parameter int unsigned L2_N    = 32,
  parameter int unsigned L3_N    = 10,
  parameter int unsigned NUM_IMG = 100,
  parameter int unsigned IMG_W   = 7,
  parameter int unsigned WDOG    = 4095
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             l1_done_i,
  input  logic             l2_done_i,
  input  logic             l3_done_i,
  output logic             l1_start_o,
  output logic             l2_start_o,
  output logic             l3_start_o,
  output logic [7:0]       neuron_idx_o,
  output logic [1:0]       layer_o,
  output logic [IMG_W-1:0] img_idx_o,
  output logic             img_done_o,
  output logic             busy_o,
  output logic             all_done_o,
  output logic             err_o
);

  localparam int unsigned WD_W = $clog2(WDOG + 1);
  localparam logic [7:0]       L1_LAST  = 8'(L1_N - 1);
  localparam logic [7:0]       L2_LAST  = 8'(L2_N - 1);
  localparam logic [7:0]       L3_LAST  = 8'(L3_N - 1);
  localparam logic [IMG_W-1:0] IMG_LAST = IMG_W'(NUM_IMG - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_NEXT_IMG, S_DONE, S_ERR
  } state_t;

  state_t           r_state;
  logic [1:0]       r_layer;
  logic [7:0]       r_nidx;
  logic [IMG_W-1:0] r_img;
  logic [WD_W-1:0]  r_wdog;
  logic             r_l1_start, r_l2_start, r_l3_start;
  logic             r_img_done, r_busy, r_all_done, r_err;

  logic             w_done_cur;
  logic             w_last_nidx;

  // Only the layer currently in flight may advance the schedule.
  always_comb begin
    w_done_cur  = 1'b0;
    w_last_nidx = 1'b0;
    unique case (r_layer)
      2'd1:    begin w_done_cur = l1_done_i; w_last_nidx = (r_nidx == L1_LAST); end
      2'd2:    begin w_done_cur = l2_done_i; w_last_nidx = (r_nidx == L2_LAST); end
      2'd3:    begin w_done_cur = l3_done_i; w_last_nidx = (r_nidx == L3_LAST); end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_layer    <= 2'd0;
      r_nidx     <= 8'd0;
      r_img      <= '0;
      r_wdog     <= '0;
      r_l1_start <= 1'b0;
      r_l2_start <= 1'b0;
      r_l3_start <= 1'b0;
      r_img_done <= 1'b0;
      r_busy     <= 1'b0;
      r_all_done <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_l1_start <= 1'b0;
      r_l2_start <= 1'b0;
      r_l3_start <= 1'b0;
      r_img_done <= 1'b0;
      if (abort_i && r_state != S_ERR) begin
        r_state    <= S_IDLE;
        r_layer    <= 2'd0;
        r_nidx     <= 8'd0;
        r_img      <= '0;
        r_wdog     <= '0;
        r_busy     <= 1'b0;
        r_all_done <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE, S_DONE: begin
            if (start_i) begin
              r_state    <= S_ISSUE;
              r_layer    <= 2'd1;
              r_nidx     <= 8'd0;
              r_img      <= '0;
              r_l1_start <= 1'b1;
              r_busy     <= 1'b1;
              r_all_done <= 1'b0;
            end
          end
          S_ISSUE: begin
            r_state <= S_WAIT;
            r_wdog  <= '0;
          end
          S_WAIT: begin
            if (w_done_cur) begin
              if (!w_last_nidx) begin
                r_state    <= S_ISSUE;
                r_nidx     <= r_nidx + 8'd1;
                r_l1_start <= (r_layer == 2'd1);
                r_l2_start <= (r_layer == 2'd2);
                r_l3_start <= (r_layer == 2'd3);
              end else if (r_layer != 2'd3) begin
                r_state    <= S_ISSUE;
                r_layer    <= r_layer + 2'd1;
                r_nidx     <= 8'd0;
                r_l2_start <= (r_layer == 2'd1);
                r_l3_start <= (r_layer == 2'd2);
              end else begin
                r_state    <= S_NEXT_IMG;
                r_img_done <= 1'b1;
              end
            end else if (r_wdog == WD_LAST) begin
              // A done on the final allowed cycle is taken above, so it wins.
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_wdog <= r_wdog + WD_W'(1);
            end
          end
          S_NEXT_IMG: begin
            if (r_img == IMG_LAST) begin
              r_state    <= S_DONE;
              r_layer    <= 2'd0;
              r_nidx     <= 8'd0;
              r_busy     <= 1'b0;
              r_all_done <= 1'b1;
            end else begin
              r_state    <= S_ISSUE;
              r_img      <= r_img + IMG_W'(1);
              r_layer    <= 2'd1;
              r_nidx     <= 8'd0;
              r_l1_start <= 1'b1;
            end
          end
          S_ERR: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign l1_start_o   = r_l1_start;
  assign l2_start_o   = r_l2_start;
  assign l3_start_o   = r_l3_start;
  assign neuron_idx_o = r_nidx;
  assign layer_o      = r_layer;
  assign img_idx_o    = r_img;
  assign img_done_o   = r_img_done;
  assign busy_o       = r_busy;
  assign all_done_o   = r_all_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_mnist_layer_sched.sv
// Bench for mnist_layer_sched: emulates the three layer controllers with random
// done latencies and checks the start schedule against an expected issue list.
module tb_mnist_layer_sched;

  localparam int unsigned L1_N    = 4;
  localparam int unsigned L2_N    = 2;
  localparam int unsigned L3_N    = 2;
  localparam int unsigned NUM_IMG = 2;
  localparam int unsigned IMG_W   = 7;
  localparam int unsigned WDOG    = 8;

  logic             clk_i = 1'b0;
  logic             rst_i, start_i, abort_i;
  logic             l1_done_i, l2_done_i, l3_done_i;
  logic             l1_start_o, l2_start_o, l3_start_o;
  logic [7:0]       neuron_idx_o;
  logic [1:0]       layer_o;
  logic [IMG_W-1:0] img_idx_o;
  logic             img_done_o, busy_o, all_done_o, err_o;

  int n_pass   = 0;
  int n_checks = 0;

  typedef struct {
    int unsigned layer;
    int unsigned nidx;
    int unsigned img;
  } ent_t;

  mnist_layer_sched #(
    .L1_N(L1_N), .L2_N(L2_N), .L3_N(L3_N),
    .NUM_IMG(NUM_IMG), .IMG_W(IMG_W), .WDOG(WDOG)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .l1_done_i(l1_done_i), .l2_done_i(l2_done_i), .l3_done_i(l3_done_i),
    .l1_start_o(l1_start_o), .l2_start_o(l2_start_o), .l3_start_o(l3_start_o),
    .neuron_idx_o(neuron_idx_o), .layer_o(layer_o), .img_idx_o(img_idx_o),
    .img_done_o(img_done_o), .busy_o(busy_o), .all_done_o(all_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({l1_start_o, l2_start_o, l3_start_o, neuron_idx_o, layer_o, img_idx_o,
                img_done_o, busy_o, all_done_o, err_o});
  endfunction

  function automatic logic [31:0] starts();
    return 32'({l3_start_o, l2_start_o, l1_start_o});
  endfunction

  function automatic int unsigned layer_n(input int unsigned l);
    return (l == 1) ? L1_N : (l == 2) ? L2_N : L3_N;
  endfunction

  task automatic clear_done();
    l1_done_i = 1'b0;
    l2_done_i = 1'b0;
    l3_done_i = 1'b0;
  endtask

  task automatic set_done(input int unsigned l);
    if (l == 1) l1_done_i = 1'b1;
    else if (l == 2) l2_done_i = 1'b1;
    else l3_done_i = 1'b1;
  endtask

  // One full run from IDLE/DONE; abort_k >= 0 aborts during the wait of that issue.
  task automatic do_run(input int dmin, input int dmax, input bit noise, input int abort_k);
    ent_t q[$];
    ent_t e;
    int   d;
    q = {};
    for (int unsigned im = 0; im < NUM_IMG; im++)
      for (int unsigned l = 1; l <= 3; l++)
        for (int unsigned n = 0; n < layer_n(l); n++)
          q.push_back('{layer: l, nidx: n, img: im});
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      e = q[k];
      check_eq("start_pulse", starts(), 32'(3'b001 << (e.layer - 1)));
      check_eq("issue_idx", 32'({layer_o, neuron_idx_o, img_idx_o}),
               32'({2'(e.layer), 8'(e.nidx), IMG_W'(e.img)}));
      check_eq("issue_flags", 32'({busy_o, all_done_o, img_done_o, err_o}), 32'(4'b1000));
      if (noise) begin
        set_done(e.layer);
        start_i = 1'b1;
      end
      d = int'($urandom_range(dmax, dmin));
      for (int w = 1; w <= d; w++) begin
        tick();
        clear_done();
        start_i = 1'b0;
        check_eq("wait_no_start", starts(), 32'd0);
        check_eq("wait_stable", 32'({layer_o, neuron_idx_o, img_idx_o, busy_o}),
                 32'({2'(e.layer), 8'(e.nidx), IMG_W'(e.img), 1'b1}));
        if (abort_k == k && w == 1) begin
          abort_i = 1'b1;
          set_done(e.layer);
          tick();
          abort_i = 1'b0;
          clear_done();
          check_eq("abort_idle", out_vec(), 32'd0);
          return;
        end
        if (w == d) set_done(e.layer);
        else if (noise) begin
          set_done((e.layer % 3) + 1);
          start_i = 1'b1;
        end
      end
      tick();
      clear_done();
      if (k == q.size() - 1 || q[k+1].img != e.img) begin
        check_eq("img_done", 32'({img_done_o, l3_start_o, l2_start_o, l1_start_o}), 32'(4'b1000));
        tick();
      end
    end
    check_eq("run_done", 32'({all_done_o, busy_o, err_o}), 32'(3'b100));
    check_eq("run_done_quiet", starts(), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    clear_done();
    repeat (3) tick();
    check_eq("reset_outputs", out_vec(), 32'd0);
    rst_i = 1'b0;
    tick();
    check_eq("idle_outputs", out_vec(), 32'd0);

    // Fixed 3-cycle done latency, then restart from DONE with random latency and noise.
    do_run(3, 3, 1'b0, -1);
    tick();
    check_eq("done_level_held", 32'({all_done_o, busy_o}), 32'(2'b10));
    do_run(1, 5, 1'b1, -1);

    // Abort in layer 2 of image 1 (issue index 13), then a clean re-run from image 0.
    do_run(1, 4, 1'b0, 13);
    tick();
    check_eq("after_abort_idle", out_vec(), 32'd0);
    do_run(1, 4, 1'b1, -1);

    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_eq("reset_from_done", out_vec(), 32'd0);

    // Watchdog: done on the last allowed cycle wins; then withhold done.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("wd_first_start", starts(), 32'd1);
    for (int w = 1; w <= int'(WDOG); w++) begin
      tick();
      check_eq("wd_edge_no_err", 32'(err_o), 32'd0);
      if (w == int'(WDOG)) l1_done_i = 1'b1;
    end
    tick();
    clear_done();
    check_eq("wd_edge_next_start", 32'({l1_start_o, neuron_idx_o, err_o}), 32'({1'b1, 8'd1, 1'b0}));
    for (int w = 1; w <= int'(WDOG); w++) begin
      tick();
      check_eq("wd_wait_no_err", 32'({err_o, busy_o}), 32'(2'b01));
    end
    tick();
    check_eq("wd_err", 32'({err_o, busy_o}), 32'(2'b10));
    start_i = 1'b1;
    abort_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("err_sticky", 32'({err_o, l3_start_o, l2_start_o, l1_start_o}), 32'(4'b1000));
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_eq("err_reset", out_vec(), 32'd0);

    // Reset in WAIT with a coincident done: no further start.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    rst_i = 1'b1;
    l1_done_i = 1'b1;
    tick();
    rst_i = 1'b0;
    clear_done();
    for (int i = 0; i < 5; i++) begin
      check_eq("rst_wait_idle", out_vec(), 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
